load_store_unit: RTL

Load/store unit sitting directly downstream of the single-cycle RISC-V datapath. It consumes the ALU address, the store operand and the memory-control strobes, and runs a request/acknowledge transaction on a word-wide data bus. It returns a sign- or zero-extended load value to the datapath's result mux. While the transaction is outstanding it stalls the core so the current instruction (PC, register write) is held until the access completes or faults.

---
 rtl/load_store_unit.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: turns the core's memory strobes into one registered request/acknowledge
// bus transaction, stalls the core while it is outstanding, and extends load data.
module load_store_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic [31:0] read_data,
  output logic        stall,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic [1:0]  dbg_state
);
  // Bus handshake: bus_req rises on entry to BUS and stays high, with bus_we/addr/be/wdata
  // stable, until the cycle in which bus_ack is sampled high or the timeout expires.
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, BUS = 2'd1, DONE = 2'd2} state_t;
  state_t state, state_nxt;

  logic [CW-1:0] cnt;
  logic [2:0]    f3_q;
  logic [1:0]    lo_q;
  logic          access, illegal, misaligned, timeout_hit;
  logic [3:0]    be_nxt;
  logic [31:0]   wdata_nxt, shifted, load_val;

  assign access      = mem_read | mem_write;
  assign timeout_hit = (cnt == CW'(TIMEOUT - 1));
  assign dbg_state   = state;
  // Reset gates stall so an abandoned access releases the core at once.
  assign stall = !reset && ((state == BUS) || ((state == IDLE) && access));

  always_comb begin
    illegal = 1'b0;
    if (mem_write) illegal = funct3[2] | (funct3[1:0] == 2'b11);
    else           illegal = (funct3 == 3'b011) | (funct3[2:1] == 2'b11);
    misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                 ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
  end

  always_comb begin
    be_nxt    = 4'b1111;
    wdata_nxt = store_data;
    case (funct3[1:0])
      2'b00: begin
        be_nxt    = 4'b0001 << addr[1:0];
        wdata_nxt = {4{store_data[7:0]}};
      end
      2'b01: begin
        be_nxt    = 4'b0011 << {addr[1], 1'b0};
        wdata_nxt = {2{store_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    shifted = bus_rdata >> {lo_q, 3'b000};
    case (f3_q)
      3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_val = {24'd0, shifted[7:0]};
      3'b101:  load_val = {16'd0, shifted[15:0]};
      default: load_val = shifted;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (access) state_nxt = (illegal || misaligned) ? DONE : BUS;
      BUS:  if (bus_ack || timeout_hit) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      read_data   <= '0;
      fault       <= 1'b0;
      fault_cause <= 2'b00;
      bus_req     <= 1'b0;
      bus_we      <= 1'b0;
      bus_addr    <= '0;
      bus_wdata   <= '0;
      bus_be      <= '0;
      cnt         <= '0;
      f3_q        <= '0;
      lo_q        <= '0;
    end else begin
      case (state)
        IDLE: if (access) begin
          if (illegal || misaligned) begin
            fault       <= 1'b1;
            fault_cause <= illegal ? 2'b10 : 2'b01;
            if (!mem_write) read_data <= '0;
          end else begin
            bus_req   <= 1'b1;
            bus_we    <= mem_write;
            bus_addr  <= {addr[31:2], 2'b00};
            bus_be    <= mem_write ? be_nxt : 4'b0000;
            bus_wdata <= mem_write ? wdata_nxt : 32'd0;
            f3_q      <= funct3;
            lo_q      <= addr[1:0];
            cnt       <= '0;
          end
        end
        BUS: begin
          if (bus_ack) begin
            bus_req <= 1'b0;
            if (!bus_we) read_data <= load_val;
          end else if (timeout_hit) begin
            bus_req     <= 1'b0;
            fault       <= 1'b1;
            fault_cause <= 2'b11;
            if (!bus_we) read_data <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          fault       <= 1'b0;
          fault_cause <= 2'b00;
        end
        default: ;
      endcase
    end
  end
endmodule
